// File: rtl/psum_ctrl_pkg.sv
// Shared types for the psum adder-tree sequencing controller.
// PSUM_PIPE_DEPTH must track the register depth of the adder tree.
package psum_ctrl_pkg;

    localparam int PSUM_PIPE_DEPTH = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

endpackage

// File: rtl/psum_pipe_tag.sv
// Tag shift register running alongside the adder tree; decodes FIFO read,
// zero-addend and write/result steering from the registered stage tags.
module psum_pipe_tag
    import psum_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  tag_t in_tag,
    output logic s1_valid,
    output logic fifo_rd_en,
    output logic fifo_zero,
    output logic fifo_wr_en,
    output logic res_valid
);

    // Stages 1..2 carry the full tag; the final stage only needs valid/last to steer.
    tag_t [PSUM_PIPE_DEPTH-2:0] tag_q, tag_d;
    logic s3_valid_q, s3_valid_d;
    logic s3_last_q, s3_last_d;

    always_comb begin
        tag_d[0] = in_tag;
        for (int i = 1; i < PSUM_PIPE_DEPTH - 1; i++) begin
            tag_d[i] = tag_q[i-1];
        end
        s3_valid_d = tag_q[PSUM_PIPE_DEPTH-2].valid;
        s3_last_d  = tag_q[PSUM_PIPE_DEPTH-2].last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= '0;
            s3_valid_q <= 1'b0;
            s3_last_q  <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            s3_valid_q <= s3_valid_d;
            s3_last_q  <= s3_last_d;
        end
    end

    assign s1_valid   = tag_q[0].valid;
    assign fifo_rd_en = tag_q[0].valid & ~tag_q[0].first;
    assign fifo_zero  = tag_q[1].valid &  tag_q[1].first;
    assign fifo_wr_en = s3_valid_q & ~s3_last_q;
    assign res_valid  = s3_valid_q &  s3_last_q;

endmodule

// File: rtl/psum_ctrl.sv
// Sequencing controller for the 3-stage psum adder tree: admits PE beats,
// schedules psum FIFO reads/writes and flags final results.
module psum_ctrl
    import psum_ctrl_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int PIX_W  = 7,
    parameter int PASS_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PIX_W-1:0]  cfg_num_pix,
    input  logic [PASS_W-1:0] cfg_num_pass,
    input  logic              pe_valid,
    output logic              pe_ready,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              fifo_zero,
    output logic              fifo_wr_en,
    output logic              fifo_clr,
    input  logic              res_afull,
    output logic              res_valid,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_e            state_q, state_d;
    logic [PIX_W-1:0]  num_pix_q, num_pix_d, pix_cnt_q, pix_cnt_d;
    logic [PASS_W-1:0] num_pass_q, num_pass_d, pass_cnt_q, pass_cnt_d;
    logic              pe_ready_q, pe_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              clr_q, clr_d;
    logic              err_q, err_d;

    logic acc, last_pass, s1_valid;
    tag_t in_tag;

    assign last_pass = (pass_cnt_q == num_pass_q - PASS_W'(1));
    // The adder tree cannot stall, so the result-buffer headroom gate acts before admission.
    assign pe_ready  = pe_ready_q & ~(last_pass & res_afull);
    assign acc       = pe_valid & pe_ready;
    assign in_tag    = '{valid: acc, first: (pass_cnt_q == '0), last: last_pass};

    psum_pipe_tag u_pipe (
        .clk        (clk),
        .rst        (rst),
        .in_tag     (in_tag),
        .s1_valid   (s1_valid),
        .fifo_rd_en (fifo_rd_en),
        .fifo_zero  (fifo_zero),
        .fifo_wr_en (fifo_wr_en),
        .res_valid  (res_valid)
    );

    always_comb begin
        state_d    = state_q;
        num_pix_d  = num_pix_q;
        num_pass_d = num_pass_q;
        pix_cnt_d  = pix_cnt_q;
        pass_cnt_d = pass_cnt_q;
        clr_d      = 1'b0;
        done_d     = 1'b0;
        err_d      = err_q | (fifo_rd_en & fifo_empty);
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_pix_d  = (cfg_num_pix > PIX_W'(DEPTH)) ? PIX_W'(DEPTH) : cfg_num_pix;
                    num_pass_d = cfg_num_pass;
                    pix_cnt_d  = '0;
                    pass_cnt_d = '0;
                    clr_d      = 1'b1;
                    err_d      = 1'b0;
                    state_d    = (cfg_num_pix == '0 || cfg_num_pass == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (acc) begin
                    if (pix_cnt_q == num_pix_q - PIX_W'(1)) begin
                        pix_cnt_d  = '0;
                        pass_cnt_d = pass_cnt_q + PASS_W'(1);
                        if (last_pass) state_d = DRAIN;
                    end else begin
                        pix_cnt_d = pix_cnt_q + PIX_W'(1);
                    end
                end
            end
            // Leave once the last beat is past stage 1 so the registered done
            // lands one cycle after its result.
            DRAIN: if (!s1_valid) state_d = DONE;
            DONE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        // Short passes: hold off a re-read until the same pixel's write has left stage 3.
        pe_ready_d = (state_d == RUN) &&
                     !((num_pix_d < PIX_W'(3)) && (pass_cnt_d != '0) && (acc || s1_valid));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            num_pix_q  <= '0;
            num_pass_q <= '0;
            pix_cnt_q  <= '0;
            pass_cnt_q <= '0;
            pe_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_pix_q  <= num_pix_d;
            num_pass_q <= num_pass_d;
            pix_cnt_q  <= pix_cnt_d;
            pass_cnt_q <= pass_cnt_d;
            pe_ready_q <= pe_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clr_q      <= clr_d;
            err_q      <= err_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign fifo_clr = clr_q;

endmodule

// File: tb/tb_psum_ctrl.sv
// Scoreboard bench for psum_ctrl: models the adder tree and psum FIFO around
// the controller and checks sequencing, final sums and job timing.
module tb_psum_ctrl;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [6:0] cfg_num_pix = '0;
    logic [7:0] cfg_num_pass = '0;
    logic       pe_valid = 1'b0;
    logic       fifo_empty = 1'b1;
    logic       res_afull = 1'b0;
    logic       pe_ready, fifo_rd_en, fifo_zero, fifo_wr_en, fifo_clr;
    logic       res_valid, busy, done, err;

    psum_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_num_pix(cfg_num_pix), .cfg_num_pass(cfg_num_pass),
        .pe_valid(pe_valid), .pe_ready(pe_ready),
        .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_zero(fifo_zero),
        .fifo_wr_en(fifo_wr_en), .fifo_clr(fifo_clr),
        .res_afull(res_afull), .res_valid(res_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0, n_bad = 0;
    bit ex_rd[N], ex_zero[N], ex_wr[N], ex_res[N], ex_clr[N];
    int exp_done = -1, done_cyc = 0, busy_chk = -1;
    bit done_seen = 0, force_empty = 0;
    int cur_pix = 0, cur_pass = 0, acc_n = 0, cur_prod = 0;
    int acc_sum[64];
    int exp_q[$], fifo_q[$];
    int p1 = 0, p2 = 0, out3 = 0, rdata = 0;
    int n_rd = 0, n_wr = 0, n_zero = 0, n_res = 0;
    int mi, mk, mpix, mnxt, mrdn, me;

    task automatic chk(input string what, input int got, input int expv);
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", what, cyc, got, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        fifo_empty = force_empty || (fifo_q.size() == 0);
    end

    // Monitor: control timing, adder/FIFO data model and result scoreboard.
    always @(negedge clk) begin
        mi = cyc % N;
        chk("stage_out", {27'd0, fifo_rd_en, fifo_zero, fifo_wr_en, res_valid, fifo_clr},
            {27'd0, ex_rd[mi], ex_zero[mi], ex_wr[mi], ex_res[mi], ex_clr[mi]});
        ex_rd[mi] = 0; ex_zero[mi] = 0; ex_wr[mi] = 0; ex_res[mi] = 0; ex_clr[mi] = 0;
        if (cyc == busy_chk) begin
            chk("busy_after_start", busy, 1);
            chk("err_after_start", err, 0);
        end
        if (done) begin
            chk("done_time", cyc, exp_done);
            done_seen = 1; done_cyc = cyc; exp_done = -1;
        end
        if (res_afull && cur_pix > 0 && cur_pass > 0 && acc_n < cur_pix * cur_pass &&
            acc_n / cur_pix == cur_pass - 1)
            chk("afull_gate", pe_ready, 0);
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                ex_rd[j] = 0; ex_zero[j] = 0; ex_wr[j] = 0; ex_res[j] = 0; ex_clr[j] = 0;
            end
            exp_q.delete();
            p1 = 0; p2 = 0; out3 = 0; acc_n = 0; cur_pix = 0; cur_pass = 0; exp_done = -1;
        end else begin
            if (fifo_clr) fifo_q.delete();
            if (res_valid) begin
                n_res++;
                if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
                else begin
                    me = exp_q.pop_front();
                    chk("result_sum", out3, me);
                end
            end
            if (fifo_zero) n_zero++;
            mnxt = p2 + (fifo_zero ? 0 : rdata);
            mrdn = rdata;
            if (fifo_rd_en) begin
                n_rd++;
                chk("read_has_data", (fifo_q.size() > 0) ? 1 : 0, force_empty ? fifo_q.size() > 0 : 1);
                if (fifo_q.size() > 0) mrdn = fifo_q.pop_front();
                else mrdn = 0;
            end
            if (fifo_wr_en) begin
                n_wr++;
                fifo_q.push_back(out3);
                chk("fifo_occupancy_ok", (fifo_q.size() <= cur_pix) ? 1 : 0, 1);
            end
            out3 = mnxt; p2 = p1; p1 = 0; rdata = mrdn;
            if (pe_valid && pe_ready) begin
                if (cur_pix == 0 || acc_n >= cur_pix * cur_pass) chk("unexpected_accept", 1, 0);
                else begin
                    mpix = acc_n % cur_pix;
                    mk   = acc_n / cur_pix;
                    p1   = cur_prod;
                    ex_rd[(cyc + 1) % N]   = (mk != 0);
                    ex_zero[(cyc + 2) % N] = (mk == 0);
                    if (mk == cur_pass - 1) begin
                        ex_res[(cyc + 3) % N] = 1;
                    end else begin
                        ex_wr[(cyc + 3) % N] = 1;
                    end
                    acc_sum[mpix] = (mk == 0) ? cur_prod : acc_sum[mpix] + cur_prod;
                    if (mk == cur_pass - 1) exp_q.push_back(acc_sum[mpix]);
                    acc_n++;
                    if (acc_n == cur_pix * cur_pass) exp_done = cyc + 4;
                end
            end
        end
    end

    // afull_mode: 0 none, 1 toggle every 2 cycles, 2 random
    task automatic run_job(input int np, input int ns, input bit rnd_v, input bit fixed,
                           input int afull_mode, input bit fe, input int rst_at,
                           input int exp_total);
        int s, t, a, b, c, d, e_one, e_rw;
        @(posedge clk); #1;
        cur_pix = np; cur_pass = ns; acc_n = 0;
        n_rd = 0; n_wr = 0; n_zero = 0; n_res = 0;
        force_empty = fe; done_seen = 0;
        cfg_num_pix = np[6:0]; cfg_num_pass = ns[7:0]; start = 1'b1;
        s = cyc;
        ex_clr[(s + 1) % N] = 1;
        busy_chk = (np == 0 || ns == 0) ? -1 : s + 1;
        exp_done = (np == 0 || ns == 0) ? s + 2 : -1;
        @(posedge clk); #1;
        start = 1'b0;
        t = 0;
        while (!done_seen && t < 4000) begin
            if (rst_at > 0 && acc_n >= rst_at) break;
            pe_valid = rnd_v ? ($urandom_range(0, 9) < 7) : 1'b1;
            if (fixed) cur_prod = 1 + 4 + 9 + 16;
            else begin
                a = $urandom_range(0, 255); b = $urandom_range(0, 255);
                c = $urandom_range(0, 255); d = $urandom_range(0, 255);
                cur_prod = a * a + b * b + c * c + d * d;
            end
            case (afull_mode)
                1: res_afull = ((cyc / 2) % 2) == 1;
                2: res_afull = ($urandom_range(0, 3) == 0);
                default: res_afull = 1'b0;
            endcase
            @(posedge clk); #1;
            t++;
        end
        pe_valid = 1'b0; res_afull = 1'b0;
        if (rst_at > 0) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("reset_outputs_zero",
                {23'd0, pe_ready, busy, done, err, fifo_rd_en, fifo_zero, fifo_wr_en, fifo_clr, res_valid}, 0);
            return;
        end
        if (!done_seen) chk("done_timeout", 0, 1);
        else if (exp_total >= 0) chk("job_cycles", done_cyc - s, exp_total);
        @(negedge clk);
        chk("busy_idle", busy, 0);
        e_one = (np > 0 && ns > 0) ? np : 0;
        e_rw  = (np > 0 && ns > 0) ? (ns - 1) * np : 0;
        chk("rd_count", n_rd, e_rw);
        chk("wr_count", n_wr, e_rw);
        chk("zero_count", n_zero, e_one);
        chk("res_count", n_res, e_one);
        chk("results_left", exp_q.size(), 0);
        chk("err_flag", err, (fe && np > 0 && ns > 1) ? 1 : 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_state",
            {22'd0, pe_ready, busy, done, err, fifo_rd_en, fifo_zero, fifo_wr_en, fifo_clr, res_valid, 1'b0}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_job(4, 1, 0, 0, 0, 0, 0, 8);
        run_job(8, 3, 0, 1, 0, 0, 0, 28);
        run_job(6, 3, 1, 0, 1, 0, 0, -1);
        run_job(2, 2, 0, 0, 0, 0, 0, -1);
        run_job(1, 3, 1, 0, 0, 0, 0, -1);
        run_job(4, 2, 0, 0, 0, 1, 0, -1);
        run_job(4, 1, 0, 0, 0, 0, 0, 8);
        run_job(0, 3, 0, 0, 0, 0, 0, 2);
        run_job(5, 0, 0, 0, 0, 0, 0, 2);
        run_job(5, 3, 0, 0, 0, 0, 7, -1);
        run_job(4, 1, 0, 0, 0, 0, 0, 8);
        for (int r = 0; r < 6; r++) begin
            run_job($urandom_range(1, 10), $urandom_range(1, 4), 1, 0, 2, 0, 0, -1);
        end
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/psum_ctrl.md
# psum_ctrl

Sequencing controller for the three-stage pipelined psum adder tree in the conv kernel. Accepts PE product beats, schedules psum-FIFO reads so stored partial sums meet the adder's last stage on time, and forces a zero addend on the first channel pass. Steers each adder result back into the FIFO or out to the result path on the last pass. Sits between the PE array, the psum FIFO, and the downstream result buffer; the adder tree itself has no stall input, so all flow control is applied before a beat enters it.

## Interface
- DEPTH, 64: psum FIFO depth; the maximum `cfg_num_pix`.
- PIX_W, 7: width of `cfg_num_pix`; must satisfy 2^PIX_W > DEPTH.
- PASS_W, 8: width of `cfg_num_pass`.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job start; sampled only in IDLE.
- cfg_num_pix  in  PIX_W  psums per pass; sampled at start.
- cfg_num_pass  in  PASS_W  channel passes per job; sampled at start.
- pe_valid  in  1  PE products valid.
- pe_ready  out  1  controller accepts a beat; a beat enters the adder tree only when `pe_valid & pe_ready`.
- fifo_empty  in  1  psum FIFO empty.
- fifo_rd_en  out  1  psum FIFO pop; the FIFO has 1-cycle read latency.
- fifo_zero  out  1  selects 0 instead of FIFO data on the adder's fifo_data input.
- fifo_wr_en  out  1  push the adder output into the psum FIFO.
- fifo_clr  out  1  one-cycle psum FIFO flush.
- res_afull  in  1  downstream result buffer almost full; asserts with ≥3 free entries remaining.
- res_valid  out  1  adder output is a final psum.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle job completion pulse.
- err  out  1  sticky FIFO underflow flag; cleared by `start` or `rst`.

## Operation
- **States and transitions**
  - IDLE: on `start`, latch config, pulse `fifo_clr`, clear counters and `err`.
    - If either config value is 0, go to DONE.
    - Otherwise go to RUN.
  - RUN: `pe_ready` = 1, except on the last pass while `res_afull` = 1, where `pe_ready` = 0.
    - Each accepted beat increments `pix_cnt`.
    - At `pix_cnt == num_pix-1`, `pix_cnt` wraps to 0 and `pass_cnt` increments.
    - Acceptance of the final beat of the final pass goes to DRAIN.
  - DRAIN: `pe_ready` = 0; wait until the valid pipe is empty, then go to DONE.
  - DONE: `done` = 1 for one cycle, then go to IDLE.
- **Valid pipe:** a 3-stage shift register. Each stage carries {valid, first, last}.
  - first = (`pass_cnt` == 0) at acceptance.
  - last = (`pass_cnt` == num_pass-1) at acceptance.
- **Per-stage actions**
  - Stage-1 valid with !first → `fifo_rd_en`.
  - Stage-2 valid with first → `fifo_zero`.
  - Stage-3 valid: if last → `res_valid`, else → `fifo_wr_en`. A single-pass job goes straight to `res_valid`.
- **Underflow:** `fifo_rd_en` while `fifo_empty` sets `err`. The read is still issued and the sequence continues.
- **FIFO occupancy:** never exceeds num_pix. The pass p+1 read of a pixel always follows the pass p write of that pixel once num_pix ≥ 3. For num_pix < 3 the controller holds `pe_ready` low until the matching write has completed.
- **Ignored inputs:** `start` outside IDLE is ignored. `pe_valid` outside RUN is ignored.
- **Reset mid-job:** returns to IDLE, clears the pipe, counters and `err`. FIFO contents are not flushed by the controller; the next `start` pulses `fifo_clr`.

## Timing
- **Reset values:** all outputs 0; `pe_ready` = 0.
- **Beat latency:** a beat accepted at cycle t produces:
  - `fifo_rd_en` at t+1;
  - FIFO data or `fifo_zero` at t+2, aligned with the adder's second-stage register;
  - `fifo_wr_en` or `res_valid` at t+3, aligned with the adder's registered output.
- **Throughput:** one beat per cycle sustained.
- **Backpressure:** `pe_ready` drops in the same cycle `res_afull` rises. At most 3 beats are in flight, which the ≥3-entry headroom covers.
- **done:** asserted exactly 1 cycle after the last `res_valid`. With zero config, `done` is asserted 2 cycles after `start`.
- **Output registration:** `busy` and `pe_ready` are registered. The stage outputs decode combinationally from pipe registers only; there is no input-to-output path except `res_afull` → `pe_ready`.

## Structure
- Shared kernel package holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - pipe-tag struct {valid, first, last};
  - `PSUM_PIPE_DEPTH` = 3, kept in sync with the adder tree.
- One sub-module, `psum_pipe_tag`: the 3-stage tag shift register with per-stage decode.

## Test plan
- Job num_pix=4, num_pass=1, continuous pe_valid → 4 `res_valid` at t+3..t+6, no FIFO traffic, `done` on the next cycle.
- num_pix=8, num_pass=3 → 16 writes then 8 results; `fifo_zero` high for exactly the first 8 beats; `fifo_rd_en` count = 16; final sums match a model with pe inputs 1,2,3,4 = 30 per beat.
- Last pass with `res_afull` toggling every 2 cycles → no beat is accepted while it is high; no result is lost; `res_valid` count = num_pix.
- num_pix=2, num_pass=2 → stall inserted; no underflow; `err` stays 0.
- Pre-flushed empty FIFO with a forced second pass → `err` = 1 sticky until the next `start`.
- `rst` asserted at mid-pass 2 → all outputs 0 the next cycle; a restart with num_pix=4, num_pass=1 completes correctly.
